// File: rtl/regfile_write_arbiter_pkg.sv
// rtl/regfile_write_arbiter_pkg.sv - shared constants and types for the register-file write arbiter
package regfile_write_arbiter_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef enum logic {
    CLEAR,
    ARB
  } arb_state_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_priority_picker.sv
// rtl/regfile_write_arbiter_rr_priority_picker.sv - combinational round-robin picker, first request at or after ptr wins
module rr_priority_picker #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // One spare bit so ptr+k never overflows before the explicit modulo-N wrap.
  logic [IW:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (!any && req[cand[IW-1:0]]) begin
        gnt[cand[IW-1:0]] = 1'b1;
        idx               = cand[IW-1:0];
        any               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the register-file write port among NUM_REQ writeback sources
module regfile_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = regfile_write_arbiter_pkg::XLEN,
  parameter int REG_AW  = regfile_write_arbiter_pkg::REG_AW,
  parameter int GW      = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*REG_AW-1:0] req_sel,
  input  logic [NUM_REQ*XLEN-1:0]   req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      clear_req,
  output logic [REG_AW-1:0]         wsel,
  output logic [XLEN-1:0]           wdata,
  output logic                      wen,
  output logic                      busy_clear,
  output logic [GW-1:0]             grant_id
);

  import regfile_write_arbiter_pkg::*;

  arb_state_t         state;
  logic [REG_AW-1:0]  idx;
  logic [GW-1:0]      ptr;

  logic [NUM_REQ-1:0] gnt;
  logic [GW-1:0]      gidx;
  logic               gany;
  logic               open;
  logic               accept;
  logic [REG_AW-1:0]  sel_g;
  logic [XLEN-1:0]    data_g;
  logic [GW-1:0]      ptr_next;

  rr_priority_picker #(
    .N  (NUM_REQ),
    .IW (GW)
  ) u_picker (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (gany)
  );

  // A clear request blocks granting in its own cycle so no write races the clear.
  assign open      = (state == ARB) && !clear_req;
  assign req_ready = open ? gnt : '0;
  assign accept    = open && gany;

  assign sel_g    = req_sel[gidx*REG_AW +: REG_AW];
  assign data_g   = req_data[gidx*XLEN +: XLEN];
  assign ptr_next = (gidx == GW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLEAR;
      idx        <= REG_AW'(1);
      ptr        <= '0;
      wen        <= 1'b0;
      wsel       <= '0;
      wdata      <= '0;
      grant_id   <= '0;
      busy_clear <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          wsel       <= idx;
          wdata      <= '0;
          wen        <= 1'b1;
          busy_clear <= 1'b1;
          if (idx == {REG_AW{1'b1}}) begin
            state <= ARB;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ARB: begin
          busy_clear <= clear_req;
          if (accept) begin
            wsel     <= sel_g;
            wdata    <= data_g;
            wen      <= (sel_g != REG_AW'(REG_ZERO));
            grant_id <= gidx;
            ptr      <= ptr_next;
          end else begin
            wen <= 1'b0;
          end
          if (clear_req) begin
            state <= CLEAR;
            idx   <= REG_AW'(1);
          end
        end
        default: begin
          state <= CLEAR;
          idx   <= REG_AW'(1);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed vector bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int XW = 32;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N*AW-1:0] req_sel;
  logic [N*XW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          clear_req;
  logic [AW-1:0] wsel;
  logic [XW-1:0] wdata;
  logic          wen;
  logic          busy_clear;
  logic [1:0]    grant_id;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_sel    (req_sel),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .clear_req  (clear_req),
    .wsel       (wsel),
    .wdata      (wdata),
    .wen        (wen),
    .busy_clear (busy_clear),
    .grant_id   (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic [4:0]  s0, s1, s2;
    logic [31:0] d0, d1, d2;
    logic [2:0]  ready;
    logic        wen;
    logic [4:0]  wsel;
    logic [31:0] wdata;
    logic [1:0]  gid;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [4:0] s0, s1, s2,
                       input logic [31:0] d0, d1, d2);
    req_valid = v;
    req_sel   = {s2, s1, s0};
    req_data  = {d2, d1, d0};
  endtask

  task automatic run_clear(input int n, input string tag);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      chk($sformatf("%s_wen_%0d", tag, k), 64'(wen), 64'd1);
      chk($sformatf("%s_wsel_%0d", tag, k), 64'(wsel), 64'(k));
      chk($sformatf("%s_wdata_%0d", tag, k), 64'(wdata), 64'd0);
      chk($sformatf("%s_busy_%0d", tag, k), 64'(busy_clear), 64'd1);
      if (k < 31) chk($sformatf("%s_ready_%0d", tag, k), 64'(req_ready), 64'd0);
    end
  endtask

  initial begin
    tv[0]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2, 3'b001, 1'b1, 5'd1, 32'hA0, 2'd0};
    tv[1]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2, 3'b010, 1'b1, 5'd2, 32'hA1, 2'd1};
    tv[2]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2, 3'b100, 1'b1, 5'd3, 32'hA2, 2'd2};
    tv[3]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2, 3'b001, 1'b1, 5'd1, 32'hA0, 2'd0};
    tv[4]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2, 3'b010, 1'b1, 5'd2, 32'hA1, 2'd1};
    tv[5]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2, 3'b100, 1'b1, 5'd3, 32'hA2, 2'd2};
    tv[6]  = '{3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 3'b001, 1'b1, 5'd5, 32'hDEADBEEF, 2'd0};
    tv[7]  = '{3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'h1234, 32'h0, 3'b010, 1'b0, 5'd0, 32'h1234, 2'd1};
    tv[8]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 5'd0, 32'h1234, 2'd1};
    tv[9]  = '{3'b011, 5'd7, 5'd8, 5'd0, 32'h77, 32'h88, 32'h0, 3'b001, 1'b1, 5'd7, 32'h77, 2'd0};
    tv[10] = '{3'b101, 5'd7, 5'd0, 5'd9, 32'h77, 32'h0, 32'h99, 3'b100, 1'b1, 5'd9, 32'h99, 2'd2};
    tv[11] = '{3'b110, 5'd0, 5'd31, 5'd9, 32'h0, 32'hFFFFFFFF, 32'h99, 3'b010, 1'b1, 5'd31, 32'hFFFFFFFF, 2'd1};

    rst_n     = 1'b0;
    clear_req = 1'b0;
    drive(3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3);
    @(negedge clk);
    @(negedge clk);
    chk("rst_wen", 64'(wen), 64'd0);
    chk("rst_wsel", 64'(wsel), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);
    chk("rst_gid", 64'(grant_id), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_busy", 64'(busy_clear), 64'd1);
    rst_n = 1'b1;
    run_clear(31, "clr0");
    chk("clr0_ready_open", 64'(req_ready), 64'b001);
    drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("clr0_done_wen", 64'(wen), 64'd0);
    chk("clr0_done_busy", 64'(busy_clear), 64'd0);

    for (int i = 0; i < 12; i++) begin
      drive(tv[i].valid, tv[i].s0, tv[i].s1, tv[i].s2, tv[i].d0, tv[i].d1, tv[i].d2);
      #1;
      chk($sformatf("tv%0d_ready", i), 64'(req_ready), 64'(tv[i].ready));
      @(negedge clk);
      chk($sformatf("tv%0d_wen", i), 64'(wen), 64'(tv[i].wen));
      chk($sformatf("tv%0d_wsel", i), 64'(wsel), 64'(tv[i].wsel));
      chk($sformatf("tv%0d_wdata", i), 64'(wdata), 64'(tv[i].wdata));
      chk($sformatf("tv%0d_gid", i), 64'(grant_id), 64'(tv[i].gid));
      chk($sformatf("tv%0d_busy", i), 64'(busy_clear), 64'd0);
    end

    drive(3'b100, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 32'h44);
    clear_req = 1'b1;
    #1;
    chk("creq_ready_blocked", 64'(req_ready), 64'd0);
    @(negedge clk);
    clear_req = 1'b0;
    chk("creq_wen_idle", 64'(wen), 64'd0);
    chk("creq_busy", 64'(busy_clear), 64'd1);
    run_clear(31, "clr1");
    chk("clr1_ready_open", 64'(req_ready), 64'b100);
    @(negedge clk);
    drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    chk("clr1_req2_wen", 64'(wen), 64'd1);
    chk("clr1_req2_wsel", 64'(wsel), 64'd4);
    chk("clr1_req2_wdata", 64'(wdata), 64'h44);
    chk("clr1_req2_gid", 64'(grant_id), 64'd2);

    drive(3'b001, 5'd6, 5'd0, 5'd0, 32'h66, 32'h0, 32'h0);
    #1;
    chk("pre_rst_ready", 64'(req_ready), 64'b001);
    @(negedge clk);
    drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    chk("pre_rst_wsel", 64'(wsel), 64'd6);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    chk("clr2_wen_idle", 64'(wen), 64'd0);
    drive(3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3);
    run_clear(16, "clr2");
    rst_n = 1'b0;
    #1;
    chk("midrst_wen", 64'(wen), 64'd0);
    chk("midrst_wsel", 64'(wsel), 64'd0);
    chk("midrst_wdata", 64'(wdata), 64'd0);
    chk("midrst_gid", 64'(grant_id), 64'd0);
    chk("midrst_busy", 64'(busy_clear), 64'd1);
    chk("midrst_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_clear(31, "clr3");
    chk("clr3_ptr_reset", 64'(req_ready), 64'b001);
    drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("clr3_done_wen", 64'(wen), 64'd0);
    chk("clr3_done_busy", 64'(busy_clear), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
